tree_fanout_node: RTL

Parametrised control node for the generated module hierarchy. Each node accepts one request from its parent, fans a start pulse out to FANOUT child instances (all at once or one after another), and collects their done/error flags. It then returns a single aggregated response upstream. Because nodes chain parent-to-child, a depth-D, width-W tree is built from identical instances. This replaces the port-less fixed-width instantiation shells.

---
 rtl/tree_pkg.sv | 23 ++
 rtl/tree_timeout_ctr.sv | 40 ++++
 rtl/tree_fanout_node.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - shared types and constants for the tree fan-out node family
//
// Purpose: state and status encodings shared by tree_fanout_node, its
//          sub-modules and anything that decodes rsp_status upstream.
// Ports:   none (package).
package tree_pkg;

   localparam int MAX_FANOUT = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_ERR     = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_t;

endpackage

// File: rtl/tree_timeout_ctr.sv
// rtl/tree_timeout_ctr.sv - saturating wait-phase timeout counter
//
// Purpose: counts enabled cycles and flags the cycle in which the count
//          reaches LIMIT. The count saturates at LIMIT and never wraps.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   clr     in  clear count to zero (wins over en)
//   en      in  count this cycle
//   expired out high in the enabled cycle that brings the count to LIMIT
//               (and any enabled cycle after that)
module tree_timeout_ctr #(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int              CW      = $clog2(LIMIT + 1);
   localparam logic [CW-1:0]   C_LIMIT = CW'(LIMIT);
   localparam logic [CW-1:0]   C_ONE   = CW'(1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != C_LIMIT)) begin
         r_cnt <= r_cnt + C_ONE;
      end
   end

   // Combinational look-ahead so the owner can leave its wait state on the
   // same edge at which the count reaches LIMIT.
   assign expired = en && (r_cnt >= (C_LIMIT - C_ONE));

endmodule

// File: rtl/tree_fanout_node.sv
// rtl/tree_fanout_node.sv - fan-out control node: start children, aggregate done/err, respond upstream
//
// Purpose: accepts one tagged request from the parent, pulses child_start
//          (broadcast or one child at a time), collects child done/error
//          flags and returns one aggregated response (OK / ERR / TIMEOUT).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   parent request handshake, req_id = tag
//   child_start           one-cycle start pulses, one bit per child
//   child_done/child_err  child completion and error (err qualified by done)
//   rsp_valid/rsp_ready   response handshake, rsp_id/rsp_status held until taken
//   busy                  high from accept until the response handshake
module tree_fanout_node
   import tree_pkg::*;
#(
   parameter int FANOUT   = 10,
   parameter int SEQ_MODE = 0,
   parameter int TIMEOUT  = 1023,
   parameter int ID_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ID_W-1:0]   req_id,
   output logic [FANOUT-1:0] child_start,
   input  logic [FANOUT-1:0] child_done,
   input  logic [FANOUT-1:0] child_err,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [1:0]        rsp_status,
   output logic              busy
);

   localparam int                IDX_W    = (FANOUT > 1) ? $clog2(FANOUT) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FANOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [FANOUT-1:0] ALL_ONES = {FANOUT{1'b1}};
   localparam bit                SEQ      = (SEQ_MODE != 0);

   state_t            r_state;
   logic [ID_W-1:0]   r_id;
   status_t           r_status;
   logic [FANOUT-1:0] r_done_mask;
   logic              r_err;
   logic [IDX_W-1:0]  r_idx;

   logic              w_in_wait;
   logic              w_issue;
   logic              w_sel_done;
   logic              w_sel_err;
   logic              w_err_next;
   logic              w_complete;
   logic              w_advance;
   logic              w_expired;
   logic [FANOUT-1:0] w_mask_next;
   logic [FANOUT-1:0] w_onehot;

   assign w_in_wait = (r_state == WAIT);
   // Outputs are forced quiet while rst is high so an abort never emits a
   // stray start pulse or response in the reset cycle itself.
   assign w_issue   = (r_state == ISSUE) && !rst;

   always_comb begin
      w_onehot        = '0;
      w_onehot[r_idx] = 1'b1;
   end

   assign w_sel_done  = child_done[r_idx];
   assign w_sel_err   = child_err[r_idx];
   assign w_mask_next = r_done_mask | child_done;

   // Sequential mode only listens to the selected child; broadcast mode
   // accumulates every child, so a level done held for many cycles is
   // absorbed by the OR and counts once.
   assign w_err_next = r_err | (SEQ ? (w_sel_done & w_sel_err)
                                    : |(child_done & child_err));
   assign w_complete = SEQ ? (w_sel_done && (r_idx == LAST_IDX))
                           : (w_mask_next == ALL_ONES);
   assign w_advance  = SEQ && w_sel_done && (r_idx != LAST_IDX);

   // The timeout window is per wait phase: clearing whenever we are not in
   // WAIT covers both the fresh accept and every sequential re-issue.
   tree_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (!w_in_wait),
      .en      (w_in_wait),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_id        <= '0;
         r_status    <= ST_OK;
         r_done_mask <= '0;
         r_err       <= 1'b0;
         r_idx       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_id        <= req_id;
                  r_done_mask <= '0;
                  r_err       <= 1'b0;
                  r_idx       <= '0;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               r_state <= WAIT;
            end
            WAIT: begin
               r_done_mask <= w_mask_next;
               r_err       <= w_err_next;
               // Completion is checked before expiry so a done landing in
               // the expiry cycle still reports OK/ERR.
               if (w_complete) begin
                  r_status <= w_err_next ? ST_ERR : ST_OK;
                  r_state  <= RESP;
               end else if (w_advance) begin
                  r_idx   <= r_idx + IDX_ONE;
                  r_state <= ISSUE;
               end else if (w_expired) begin
                  r_status <= ST_TIMEOUT;
                  r_state  <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (r_state == IDLE) && !rst;
   assign child_start = {FANOUT{w_issue}} & (SEQ ? w_onehot : ALL_ONES);
   assign rsp_valid   = (r_state == RESP) && !rst;
   assign rsp_id      = r_id;
   assign rsp_status  = r_status;
   assign busy        = (r_state != IDLE) && !rst;

endmodule
